// File: rtl/verinject_logger_pkg.sv
// verinject_logger_pkg: shared constants and types for the injection event logger.
//   VERINJECT_NO_INJECT - injector bus idle value
//   CYCLE_W / BIT_W     - widths of the logged cycle number and bit index
//   inject_event_t      - one logged injection {cycle, bit_index}
//   mm_state_t          - mismatch tracking states
package verinject_logger_pkg;
    localparam logic [31:0] VERINJECT_NO_INJECT = 32'hFFFF_FFFF;
    localparam int CYCLE_W = 48;
    localparam int BIT_W = 32;
    typedef struct packed {
        logic [CYCLE_W-1:0] cycle;
        logic [BIT_W-1:0]   bit_index;
    } inject_event_t;
    typedef enum logic [1:0] {IDLE, ARMED, CAPTURED} mm_state_t;
endpackage

// File: rtl/verinject_event_fifo.sv
// verinject_event_fifo: synchronous circular-buffer FIFO with full/empty flags.
//   clock, reset_n - rising-edge clock, asynchronous active-low reset (pointers only)
//   push, din      - write request and data; refused when full unless popping too
//   pop            - consume the head entry; ignored when empty
//   dout           - head entry, driven straight from storage
//   full, empty    - occupancy flags
module verinject_event_fifo
    import verinject_logger_pkg::*;
#(
    parameter int  DEPTH = 16,
    parameter type T     = inject_event_t
) (
    input  logic clock,
    input  logic reset_n,
    input  logic push,
    input  T     din,
    input  logic pop,
    output T     dout,
    output logic full,
    output logic empty
);
    localparam int AW = $clog2(DEPTH);
    T           mem [DEPTH];
    logic [AW:0] wptr, rptr;
    logic        do_push, do_pop;
    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty   = wptr == rptr;
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // When full, a simultaneous pop frees the head slot, which is the write slot.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rptr[AW-1:0]];
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end
    always_ff @(posedge clock) begin
        if (do_push) mem[wptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/verinject_event_logger.sv
// verinject_event_logger: records injector events {cycle, bit} in a FIFO for readout.
//   clock, reset_n              - rising-edge clock, asynchronous active-low reset
//   verinject__injector_state   - injector bus; all-ones means no injection
//   cycle_number                - free-running cycle count from the injector
//   mismatch                    - real/injected comparison failed this cycle
//   out_valid/out_ready         - readout handshake; out_cycle/out_bit are the head entry
//   dropped                     - saturating count of injections lost to overflow
//   mismatch_latency(_valid)    - cycles from last injection to first mismatch after it
// Optional feature: define VERINJECT_LOGGER_MISMATCH_EN to build mismatch latency tracking;
// otherwise mismatch is ignored and the latency outputs are tied to zero.
module verinject_event_logger
    import verinject_logger_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [BIT_W-1:0]   verinject__injector_state,
    input  logic [CYCLE_W-1:0] cycle_number,
    input  logic               mismatch,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CYCLE_W-1:0] out_cycle,
    output logic [BIT_W-1:0]   out_bit,
    output logic [CNT_W-1:0]   dropped,
    output logic [CYCLE_W-1:0] mismatch_latency,
    output logic               mismatch_latency_valid
);
    logic          ev, full, empty, drop;
    inject_event_t head;
    assign ev = verinject__injector_state != VERINJECT_NO_INJECT;
    verinject_event_fifo #(.DEPTH(DEPTH), .T(inject_event_t)) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (ev),
        .din     ('{cycle: cycle_number, bit_index: verinject__injector_state}),
        .pop     (out_ready),
        .dout    (head),
        .full    (full),
        .empty   (empty)
    );
    assign out_valid = !empty;
    assign out_cycle = head.cycle;
    assign out_bit   = head.bit_index;
    // Full implies non-empty, so out_ready alone means a pop will make room.
    assign drop = ev && full && !out_ready;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)                  dropped <= '0;
        else if (drop && dropped != '1) dropped <= dropped + 1'b1;
    end
`ifdef VERINJECT_LOGGER_MISMATCH_EN
    mm_state_t          state, state_nx;
    logic [CYCLE_W-1:0] t_inj, t_inj_nx, lat, lat_nx;
    logic               lat_v, lat_v_nx;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            t_inj <= '0;
            lat   <= '0;
            lat_v <= 1'b0;
        end else begin
            state <= state_nx;
            t_inj <= t_inj_nx;
            lat   <= lat_nx;
            lat_v <= lat_v_nx;
        end
    end
    // A new injection takes priority over a mismatch arriving in the same cycle.
    always_comb begin
        state_nx = state;
        t_inj_nx = t_inj;
        lat_nx   = lat;
        lat_v_nx = lat_v;
        if (ev) begin
            state_nx = ARMED;
            t_inj_nx = cycle_number;
            lat_v_nx = 1'b0;
        end else if (state == ARMED && mismatch) begin
            state_nx = CAPTURED;
            lat_nx   = cycle_number - t_inj;
            lat_v_nx = 1'b1;
        end
    end
    assign mismatch_latency       = lat;
    assign mismatch_latency_valid = lat_v;
`else
    logic unused_mismatch;
    assign unused_mismatch        = mismatch;
    assign mismatch_latency       = '0;
    assign mismatch_latency_valid = 1'b0;
`endif
endmodule

// File: doc/verinject_event_logger.md
# verinject_event_logger

Synthesizable sink for the `verinject__injector_state` bus: it observes fault injections issued by the injector and records each one, tagged with its cycle number, in an on-chip FIFO. A host or a testbench drains the FIFO through a valid/ready readout port. It sits beside the `__injected` design and the injector as the hardware counterpart of the simulation-only monitor, so injection campaigns can be audited on FPGA.

## Interface
Parameters:
- `DEPTH`, 16 — FIFO entries; power of two, at least 2.
- `CNT_W`, 16 — width of the dropped-event counter.

Ports:
- `clock`  in  1  — the single clock; all logic is on the rising edge.
- `reset_n`  in  1  — asynchronous, active-low reset.
- `verinject__injector_state`  in  32  — injector bus: `32'hFFFF_FFFF` means no injection this cycle; any other value is the global bit index being flipped.
- `cycle_number`  in  48  — free-running cycle count from the injector.
- `mismatch`  in  1  — real/injected output comparison failed this cycle.
- `out_valid`  out  1  — head entry available.
- `out_ready`  in  1  — consumer accepts the head entry.
- `out_cycle`  out  48  — cycle of the head injection.
- `out_bit`  out  32  — bit index of the head injection.
- `dropped`  out  CNT_W  — injections lost to overflow; saturating.
- `mismatch_latency`  out  48  — cycles from the last injection to the first mismatch after it.
- `mismatch_latency_valid`  out  1  — `mismatch_latency` holds a captured value.

## Operation
- Event: `verinject__injector_state != 32'hFFFF_FFFF`, sampled at the rising edge. Push `{cycle_number, verinject__injector_state}`.
- FIFO: circular buffer with `log2(DEPTH)+1`-bit read and write pointers. Full when the MSBs differ and the low bits are equal. Empty when the pointers are equal. Pointers wrap modulo `2*DEPTH`.
- Pop: occurs when `out_valid && out_ready`. `out_cycle` and `out_bit` are driven straight from the head entry. The head stays stable while `out_valid` is high and `out_ready` is low.
- Overflow: an event arriving while full and without a simultaneous pop is discarded, and `dropped` increments. `dropped` saturates at all-ones and never wraps.
- Full with simultaneous pop: the push is accepted and no event is dropped.
- Empty with simultaneous push: `out_valid` is low in that cycle. The entry is visible from the next cycle.
- Mismatch tracking states:
  - IDLE: wait for an injection.
  - ARMED: an injection has occurred; hold `t_inj`.
  - CAPTURED: a mismatch has been seen and the latency recorded.
- Mismatch tracking transitions:
  - Any injection: capture `t_inj`, go to ARMED, clear `mismatch_latency_valid`.
  - ARMED with `mismatch`: `mismatch_latency <= cycle_number - t_inj` (modulo 2^48), set valid, go to CAPTURED.
  - Injection and `mismatch` in the same cycle: the injection wins. The state becomes ARMED with the new `t_inj`, and nothing is captured.
  - A `mismatch` in IDLE or CAPTURED is ignored.
- Reset (asynchronous, at any time, including mid-readout): pointers cleared, `out_valid=0`, `dropped=0`, state IDLE, `mismatch_latency=0`, `mismatch_latency_valid=0`. FIFO storage is not reset; `out_cycle`/`out_bit` are don't-care while `out_valid=0`.

## Timing
- Push-to-`out_valid` latency: 1 cycle.
- Pop takes effect at the edge where `out_valid && out_ready`. The next entry is presented in the following cycle with no bubble.
- `dropped` updates 1 cycle after the dropped event.
- `mismatch_latency_valid` rises 1 cycle after the mismatch edge.
- Throughput: one push and one pop per cycle.

## Configuration
- `VERINJECT_LOGGER_MISMATCH_EN` defined: mismatch tracking FSM present as described.
- Undefined:
  - FSM, `t_inj` and latency registers removed.
  - `mismatch` ignored.
  - `mismatch_latency` tied to 0 and `mismatch_latency_valid` tied to 0.
  - The port list is unchanged.

## Structure
- Package `verinject_logger_pkg` holds:
  - `VERINJECT_NO_INJECT = 32'hFFFF_FFFF`
  - `CYCLE_W = 48`
  - `BIT_W = 32`
  - typedef `inject_event_t` (`cycle`, `bit_index`)
  - enum `mm_state_t` (`IDLE`, `ARMED`, `CAPTURED`)
- Sub-module `verinject_event_fifo`: generic synchronous FIFO (`DEPTH`, `inject_event_t`) with full/empty flags. The top level owns the drop counter and the FSM.

## Test plan
- Reset, then injections at bits 5, 9 and 200 on consecutive cycles, `out_ready=1` -> three entries read in order with matching cycles; `dropped=0`.
- `out_ready=0`, 20 injections with `DEPTH=16` -> first 16 retained, `dropped=4`. Then drain -> entries 0..15 in order and `out_valid` falls.
- FIFO full, one injection with `out_ready=1` in the same cycle -> accepted, `dropped` unchanged, occupancy stays 16.
- `CNT_W=4`, 20 overflow drops -> `dropped` holds `4'hF`.
- Macro defined: injection at cycle 100, `mismatch` at cycles 107 and 110 -> `mismatch_latency=7`, valid set, the cycle-110 mismatch ignored. A new injection at cycle 120 -> valid clears.
- `reset_n` pulsed low asynchronously mid-drain with 5 entries queued -> `out_valid=0`, `dropped=0` and `mismatch_latency_valid=0` immediately; the next injection appears as the sole entry.
